// File: rtl/psubsb_seq.sv
// psubsb_seq: multi-cycle packed saturating sub-word subtractor.
// Computes Diff = A - B lane by lane, one lane per clock. Every lane is an
// independent signed LANE_W-bit value that saturates to MAX/MIN on overflow.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous, active-high reset (aborts any operation in flight)
//   start  launch request, only accepted in IDLE
//   A, B   packed minuend / subtrahend, lane i = [i*LANE_W +: LANE_W]
//   busy   high while in RUN and DONE
//   done   one-cycle pulse once Diff/ovfl hold the final result
//   Diff   packed saturated difference (registered)
//   ovfl   per-lane saturation flags (registered)
module psubsb_seq #(
  parameter int LANES  = 4,
  parameter int LANE_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LANES*LANE_W-1:0] A,
  input  logic [LANES*LANE_W-1:0] B,
  output logic                    busy,
  output logic                    done,
  output logic [LANES*LANE_W-1:0] Diff,
  output logic [LANES-1:0]        ovfl
);

  localparam int W  = LANES * LANE_W;
  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [LANE_W-1:0] LANE_MAX = {1'b0, {(LANE_W-1){1'b1}}};
  localparam logic [LANE_W-1:0] LANE_MIN = {1'b1, {(LANE_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;

  logic [LANE_W-1:0] a_k;
  logic [LANE_W-1:0] b_k;
  logic [LANE_W:0]   d_wide;
  logic [LANE_W-1:0] lane_res;
  logic              lane_ovf;
  logic              last_lane;

  assign last_lane = (cnt == CW'(LANES - 1));

  // Lane arithmetic is one extra bit wide; overflow shows up as the top two
  // bits disagreeing, and the top bit then gives the saturation direction.
  always_comb begin
    a_k      = op_a[cnt*LANE_W +: LANE_W];
    b_k      = op_b[cnt*LANE_W +: LANE_W];
    d_wide   = {a_k[LANE_W-1], a_k} - {b_k[LANE_W-1], b_k};
    lane_ovf = (d_wide[LANE_W] != d_wide[LANE_W-1]);
    lane_res = d_wide[LANE_W-1:0];
    if (lane_ovf) begin
      lane_res = d_wide[LANE_W] ? LANE_MIN : LANE_MAX;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (last_lane) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // done is registered from the DONE state, so it rises one edge after the
  // last lane is written and coincides with the first IDLE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      op_a  <= '0;
      op_b  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      Diff  <= '0;
      ovfl  <= '0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
      done  <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            op_a <= A;
            op_b <= B;
            Diff <= '0;
            ovfl <= '0;
            cnt  <= '0;
          end
        end
        RUN: begin
          Diff[cnt*LANE_W +: LANE_W] <= lane_res;
          ovfl[cnt]                  <= lane_ovf;
          if (!last_lane) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_psubsb_seq.sv
// tb_psubsb_seq: self-checking bench for psubsb_seq. Directed scenarios plus
// randomized operands, compared against a lane-wise integer reference model.
module tb_psubsb_seq;

  localparam int LANES  = 4;
  localparam int LANE_W = 4;
  localparam int W      = LANES * LANE_W;

  logic          clk;
  logic          rst;
  logic          start;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          busy;
  logic          done;
  logic [W-1:0]  Diff;
  logic [LANES-1:0] ovfl;

  int checks;
  int errors;

  psubsb_seq #(.LANES(LANES), .LANE_W(LANE_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Diff  (Diff),
    .ovfl  (ovfl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: per-lane signed integer subtraction clamped to the lane range.
  task automatic refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] diff, output logic [LANES-1:0] ov);
    int sa, sb, d;
    int hi, lo;
    logic [W-1:0] tmp;
    hi   = (1 << (LANE_W - 1)) - 1;
    lo   = -(1 << (LANE_W - 1));
    diff = '0;
    ov   = '0;
    for (int i = 0; i < LANES; i++) begin
      sa = int'(a[i*LANE_W +: LANE_W]);
      sb = int'(b[i*LANE_W +: LANE_W]);
      if (sa > hi) sa = sa - (1 << LANE_W);
      if (sb > hi) sb = sb - (1 << LANE_W);
      d = sa - sb;
      if (d > hi) begin
        d = hi;
        ov[i] = 1'b1;
      end else if (d < lo) begin
        d = lo;
        ov[i] = 1'b1;
      end
      tmp  = W'(d & ((1 << LANE_W) - 1));
      diff = diff | (tmp << (i * LANE_W));
    end
  endtask

  // Launch one operation and wait (bounded) for done, measuring latency.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               output int edges, output int busy_cycles);
    @(negedge clk);
    A     = a;
    B     = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start       = 1'b0;
    edges       = 0;
    busy_cycles = 0;
    while (!done && edges < 20) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic runAndCheck(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    int edges, bc;
    logic [W-1:0] ed;
    logic [LANES-1:0] eo;
    refModel(a, b, ed, eo);
    applyStimulus(a, b, edges, bc);
    checkOutput({tag, "_latency"}, 64'(edges), 64'(LANES + 1));
    checkOutput({tag, "_diff"}, 64'(Diff), 64'(ed));
    checkOutput({tag, "_ovfl"}, 64'(ovfl), 64'(eo));
  endtask

  initial begin
    int edges, bc, done_cnt, busy_seen, t1, t2, cyc;
    logic [W-1:0] ra, rb;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    A      = '0;
    B      = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_diff", 64'(Diff), 64'd0);
    checkOutput("reset_ovfl", 64'(ovfl), 64'd0);
    rst = 1'b0;

    // No saturation, with explicit latency and busy length.
    applyStimulus(16'h7354, 16'h1232, edges, bc);
    checkOutput("nosat_latency", 64'(edges), 64'd5);
    checkOutput("nosat_busy_cycles", 64'(bc), 64'd5);
    checkOutput("nosat_diff", 64'(Diff), 64'h6122);
    checkOutput("nosat_ovfl", 64'(ovfl), 64'h0);
    @(negedge clk);
    checkOutput("nosat_done_width", 64'(done), 64'd0);
    checkOutput("nosat_diff_hold", 64'(Diff), 64'h6122);

    runAndCheck("possat", 16'h7000, 16'h8000);
    checkOutput("possat_const", 64'(Diff), 64'h7000);
    runAndCheck("negsat", 16'h8081, 16'h8012);
    checkOutput("negsat_const", 64'(Diff), 64'h008F);
    checkOutput("negsat_ovfl_const", 64'(ovfl), 64'b0010);

    // Start and operand changes during RUN must be ignored.
    @(negedge clk);
    A = 16'h1111; B = 16'h1111; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    A = 16'hFFFF; B = 16'hFFFF;
    done_cnt = 0; busy_seen = 0;
    for (int i = 0; i < 16; i++) begin
      start = (i < 3) ? 1'b1 : 1'b0;
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          checkOutput("ignore_diff", 64'(Diff), 64'h0000);
          checkOutput("ignore_ovfl", 64'(ovfl), 64'h0);
        end
      end
      if (i > 6 && busy) busy_seen++;
      @(negedge clk);
    end
    checkOutput("ignore_done_count", 64'(done_cnt), 64'd1);
    checkOutput("ignore_no_relaunch", 64'(busy_seen), 64'd0);

    // Reset two RUN edges into an operation aborts it silently.
    @(negedge clk);
    A = 16'h7777; B = 16'h8888; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_done", 64'(done), 64'd0);
    checkOutput("midrst_diff", 64'(Diff), 64'd0);
    checkOutput("midrst_ovfl", 64'(ovfl), 64'd0);
    rst = 1'b0;
    done_cnt = 0;
    repeat (8) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    checkOutput("midrst_no_done", 64'(done_cnt), 64'd0);
    runAndCheck("postrst", 16'h0001, 16'h0001);

    // Back-to-back with start held high.
    @(negedge clk);
    A = 16'h4321; B = 16'h1111; start = 1'b1;
    cyc = 0; t1 = -1; t2 = -1;
    while (t2 < 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        if (t1 < 0) begin
          t1 = cyc;
          checkOutput("b2b_diff1", 64'(Diff), 64'h3210);
          @(negedge clk);
          cyc++;
          checkOutput("b2b_clear", 64'(Diff), 64'h0000);
        end else begin
          t2 = cyc;
          start = 1'b0;
          checkOutput("b2b_diff2", 64'(Diff), 64'h3210);
        end
      end
    end
    start = 1'b0;
    checkOutput("b2b_spacing", 64'(t2 - t1), 64'd6);

    // Randomized operands against the reference model.
    for (int n = 0; n < 30; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      runAndCheck("rand", ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
